// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential instruction fetcher feeding a small FIFO.
// A new fetch is requested whenever the queue has space. The queue head
// (instruction, its PC and PC+STEP) is offered to the consumer with a
// valid/ready handshake. A redirect flushes the queue and restarts
// fetching at the new PC. Reset is synchronous and active-low.
//
// Ports:
//   clock, resetN          - clock and synchronous active-low reset
//   imemReq, imemAddr      - fetch request and address (combinational req)
//   imemAck, imemData      - same-cycle accept and instruction word
//   redirect, redirectPc   - flush queue and restart fetch at redirectPc
//   instrValid, instr,     - queue head: valid flag, instruction word,
//   instrPc, instrPcPlus4  -   its address and address+STEP (zero if empty)
//   instrReady             - consumer accepts the head
//   count                  - current occupancy (0..DEPTH)
module instr_fetch_queue #(
   parameter int unsigned      WIDTH    = 32,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter int unsigned      STEP     = 4
) (
   input  logic                       clock,
   input  logic                       resetN,
   output logic                       imemReq,
   output logic [WIDTH-1:0]           imemAddr,
   input  logic                       imemAck,
   input  logic [WIDTH-1:0]           imemData,
   input  logic                       redirect,
   input  logic [WIDTH-1:0]           redirectPc,
   output logic                       instrValid,
   output logic [WIDTH-1:0]           instr,
   output logic [WIDTH-1:0]           instrPc,
   output logic [WIDTH-1:0]           instrPcPlus4,
   input  logic                       instrReady,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] data_mem [DEPTH];
   logic [WIDTH-1:0] pc_mem   [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [WIDTH-1:0] fetch_pc;
   logic             push;
   logic             pop;
   logic             full;

   // Request only when not in reset, not redirecting and space remains.
   assign full       = (count == CNT_W'(DEPTH));
   assign imemReq    = resetN && !redirect && !full;
   assign imemAddr   = fetch_pc;
   assign push       = imemReq && imemAck;
   assign instrValid = (count != CNT_W'(0));
   assign pop        = instrValid && instrReady;

   // Head view is forced to zero while the queue is empty.
   assign instr        = instrValid ? data_mem[head] : '0;
   assign instrPc      = instrValid ? pc_mem[head] : '0;
   assign instrPcPlus4 = instrValid ? (pc_mem[head] + WIDTH'(STEP)) : '0;

   // Queue storage; contents need no reset since count gates visibility.
   always_ff @(posedge clock) begin
      if (push) begin
         data_mem[tail] <= imemData;
         pc_mem[tail]   <= fetch_pc;
      end
   end

   // Pointers, occupancy and fetch PC. Reset beats redirect beats push/pop.
   always_ff @(posedge clock) begin
      if (!resetN) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         fetch_pc <= RESET_PC;
      end else if (redirect) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         fetch_pc <= redirectPc;
      end else begin
         if (push) begin
            tail     <= tail + PTR_W'(1);
            fetch_pc <= fetch_pc + WIDTH'(STEP);
         end
         if (pop) begin
            head <= head + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
